// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad front end: row count and debounce FSM states.
package keypad_pkg;

  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } kbd_db_state_t;

endpackage

// File: rtl/keypad_debouncer_sync_chain.sv
// Multi-flop synchronizer bringing asynchronous row lines into the clk domain.
module sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[STAGES-1];

endmodule

// File: rtl/keypad_debouncer.sv
// Keypad row debouncer: synchronizes the raw rows, then qualifies presses and
// releases with DB_COUNT consecutive matching samples taken on sample_en.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_COUNT    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_en,
  input  logic [NUM_ROWS-1:0] rows_raw,
  output logic [NUM_ROWS-1:0] rows_clean,
  output logic                key_down,
  output logic                press_pulse,
  output logic                release_pulse
);

  localparam int CNT_W = $clog2(DB_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DB_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_ROWS-1:0] sync;
  kbd_db_state_t       state_q;
  logic [NUM_ROWS-1:0] cand_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_inc;
  logic [NUM_ROWS-1:0] rows_clean_q;
  logic                key_down_q;
  logic                press_q;
  logic                release_q;

  sync_chain #(
    .WIDTH  (NUM_ROWS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .data_i  (rows_raw),
    .data_o  (sync)
  );

  assign cnt_inc = cnt_q + CNT_ONE;

  // Outputs are updated alongside the state so nothing combinational reaches a port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      rows_clean_q <= '0;
      key_down_q   <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (sample_en) begin
        case (state_q)
          IDLE: begin
            if (sync != '0) begin
              cand_q  <= sync;
              cnt_q   <= CNT_ONE;
              state_q <= PRESS_WAIT;
            end
          end
          PRESS_WAIT: begin
            if (sync == '0) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (sync == cand_q) begin
              if (cnt_inc == CNT_DONE) begin
                state_q      <= HELD;
                rows_clean_q <= cand_q;
                key_down_q   <= 1'b1;
                press_q      <= 1'b1;
                cnt_q        <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cand_q <= sync;
              cnt_q  <= CNT_ONE;
            end
          end
          HELD: begin
            if (sync != cand_q) begin
              state_q <= REL_WAIT;
              cnt_q   <= CNT_ONE;
            end
          end
          REL_WAIT: begin
            // A returning match is contact bounce; any other code counts toward release.
            if (sync == cand_q) begin
              state_q <= HELD;
              cnt_q   <= '0;
            end else if (cnt_inc == CNT_DONE) begin
              state_q      <= IDLE;
              rows_clean_q <= '0;
              cand_q       <= '0;
              key_down_q   <= 1'b0;
              release_q    <= 1'b1;
              cnt_q        <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign rows_clean    = rows_clean_q;
  assign key_down      = key_down_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer with SYNC_STAGES=2, DB_COUNT=4.
module tb_keypad_debouncer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sample_en;
  logic [3:0] rows_raw;
  logic [3:0] rows_clean;
  logic       key_down;
  logic       press_pulse;
  logic       release_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  keypad_debouncer #(
    .SYNC_STAGES (2),
    .DB_COUNT    (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_en     (sample_en),
    .rows_raw      (rows_raw),
    .rows_clean    (rows_clean),
    .key_down      (key_down),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      n_checks++;
      if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
        n_fail++;
        $display("FAIL pulse_overlap: press=%b release=%b, required not both high", press_pulse, release_pulse);
      end
    end
  end

  // Step k: drive inputs, clock edge k, then observe 1ns later (shows clk k+1 values).
  task automatic tick(input logic [3:0] v, input logic en);
    rows_raw  = v;
    sample_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    rows_raw  = 4'b0000;
    sample_en = 1'b1;
    #1;
    n_checks++;
    if (rows_clean !== 4'b0000) begin n_fail++; $display("FAIL reset_rows_clean: got %b want 0000", rows_clean); end
    n_checks++;
    if (key_down !== 1'b0) begin n_fail++; $display("FAIL reset_key_down: got %b want 0", key_down); end
    n_checks++;
    if (press_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_press: got %b want 0", press_pulse); end
    n_checks++;
    if (release_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_release: got %b want 0", release_pulse); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic release_key(input string tag, input logic [3:0] held);
    for (int k = 1; k <= 8; k++) begin
      tick(4'b0000, 1'b1);
      n_checks++;
      if (release_pulse !== (k == 6)) begin n_fail++; $display("FAIL %s_release_pulse step %0d: got %b want %b", tag, k, release_pulse, (k == 6)); end
      n_checks++;
      if (rows_clean !== ((k >= 6) ? 4'b0000 : held)) begin n_fail++; $display("FAIL %s_release_rows step %0d: got %b", tag, k, rows_clean); end
      n_checks++;
      if (key_down !== (k < 6)) begin n_fail++; $display("FAIL %s_release_key_down step %0d: got %b want %b", tag, k, key_down, (k < 6)); end
      n_checks++;
      if (press_pulse !== 1'b0) begin n_fail++; $display("FAIL %s_release_no_press step %0d: got %b want 0", tag, k, press_pulse); end
    end
    $display("%s release done", tag);
  endtask

  task automatic test_clean_press;
    for (int k = 1; k <= 8; k++) begin
      tick(4'b0100, 1'b1);
      n_checks++;
      if (press_pulse !== (k == 6)) begin n_fail++; $display("FAIL clean_press_pulse step %0d: got %b want %b", k, press_pulse, (k == 6)); end
      n_checks++;
      if (rows_clean !== ((k >= 6) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL clean_press_rows step %0d: got %b", k, rows_clean); end
      n_checks++;
      if (key_down !== (k >= 6)) begin n_fail++; $display("FAIL clean_press_key_down step %0d: got %b want %b", k, key_down, (k >= 6)); end
    end
    $display("test_clean_press done");
    release_key("clean", 4'b0100);
  endtask

  task automatic test_press_bounce;
    int pulses = 0;
    for (int k = 1; k <= 14; k++) begin
      tick((k == 3) ? 4'b0000 : 4'b0100, 1'b1);
      if (press_pulse === 1'b1) pulses++;
      n_checks++;
      if (press_pulse !== (k == 9)) begin n_fail++; $display("FAIL press_bounce_pulse step %0d: got %b want %b", k, press_pulse, (k == 9)); end
      n_checks++;
      if (key_down !== (k >= 9)) begin n_fail++; $display("FAIL press_bounce_key_down step %0d: got %b want %b", k, key_down, (k >= 9)); end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL press_bounce_count: got %0d want 1", pulses); end
    n_checks++;
    if (rows_clean !== 4'b0100) begin n_fail++; $display("FAIL press_bounce_rows: got %b want 0100", rows_clean); end
    $display("test_press_bounce done");
  endtask

  task automatic test_release_bounce;
    for (int k = 1; k <= 14; k++) begin
      tick((k == 3) ? 4'b0100 : 4'b0000, 1'b1);
      n_checks++;
      if (release_pulse !== (k == 9)) begin n_fail++; $display("FAIL release_bounce_pulse step %0d: got %b want %b", k, release_pulse, (k == 9)); end
      n_checks++;
      if (rows_clean !== ((k >= 9) ? 4'b0000 : 4'b0100)) begin n_fail++; $display("FAIL release_bounce_rows step %0d: got %b", k, rows_clean); end
      n_checks++;
      if (key_down !== (k < 9)) begin n_fail++; $display("FAIL release_bounce_key_down step %0d: got %b want %b", k, key_down, (k < 9)); end
    end
    $display("test_release_bounce done");
  endtask

  task automatic test_gated;
    for (int k = 1; k <= 18; k++) begin
      tick(4'b0001, (k % 4) == 0);
      n_checks++;
      if (press_pulse !== (k == 16)) begin n_fail++; $display("FAIL gated_press_pulse step %0d: got %b want %b", k, press_pulse, (k == 16)); end
      n_checks++;
      if (rows_clean !== ((k >= 16) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL gated_rows step %0d: got %b", k, rows_clean); end
    end
    $display("test_gated done");
    release_key("gated", 4'b0001);
  endtask

  task automatic test_key_change;
    for (int k = 1; k <= 12; k++) begin
      tick((k <= 3) ? 4'b0010 : 4'b1000, 1'b1);
      n_checks++;
      if (press_pulse !== (k == 9)) begin n_fail++; $display("FAIL key_change_pulse step %0d: got %b want %b", k, press_pulse, (k == 9)); end
      n_checks++;
      if (rows_clean !== ((k >= 9) ? 4'b1000 : 4'b0000)) begin n_fail++; $display("FAIL key_change_rows step %0d: got %b", k, rows_clean); end
    end
    $display("test_key_change done");
    release_key("key_change", 4'b1000);
  endtask

  task automatic test_reset_mid;
    for (int k = 1; k <= 5; k++) begin
      tick(4'b0100, 1'b1);
      n_checks++;
      if (press_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_mid_early_press step %0d: got %b want 0", k, press_pulse); end
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({rows_clean, key_down, press_pulse, release_pulse} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got rows=%b kd=%b pp=%b rp=%b want all 0", rows_clean, key_down, press_pulse, release_pulse);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rows_clean !== 4'b0000 || key_down !== 1'b0) begin n_fail++; $display("FAIL reset_mid_held: rows=%b kd=%b want 0", rows_clean, key_down); end
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(4'b0100, 1'b1);
      n_checks++;
      if (press_pulse !== (k == 6)) begin n_fail++; $display("FAIL reset_mid_press step %0d: got %b want %b", k, press_pulse, (k == 6)); end
      n_checks++;
      if (rows_clean !== ((k >= 6) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL reset_mid_rows step %0d: got %b", k, rows_clean); end
    end
    $display("test_reset_mid done");
    release_key("reset_mid", 4'b0100);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_gated();
    test_key_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_debouncer.md
KEYPAD_DEBOUNCER -- requirements
Module: keypad_debouncer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops per row (legal values are 2 or more).
REQ-002 Parameter DB_COUNT, default 4, SHALL set the number of consecutive stable samples required to accept a press or release (legal values are 2 or more).
REQ-003 clk  input  1  SHALL be the single block clock; all flops are rising-edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 sample_en  input  1  SHALL be the sample qualifier from the scan-rate divider; debounce logic advances only when it is high.
REQ-006 rows_raw  input  4  SHALL carry the raw, asynchronous keypad row lines (1 = pressed).
REQ-007 rows_clean  output  4  SHALL carry the debounced row vector fed to the key scanner.
REQ-008 key_down  output  1  SHALL be high while a debounced key is held (state HELD or REL_WAIT).
REQ-009 press_pulse  output  1  SHALL be a one-clk pulse when a press is accepted.
REQ-010 release_pulse  output  1  SHALL be a one-clk pulse when a release is accepted.

Function
REQ-011 rows_raw SHALL pass through SYNC_STAGES flops clocked every clk, independent of sample_en; the last stage is called sync.
REQ-012 The FSM SHALL have states IDLE, PRESS_WAIT, HELD, REL_WAIT, with register cand[3:0] and counter cnt of width $clog2(DB_COUNT+1).
REQ-013 With sample_en low, the FSM, cand, cnt and rows_clean SHALL hold, and both pulses SHALL be 0.
REQ-014 IDLE, on a sample with sync!=0: cand<=sync, cnt<=1, go to PRESS_WAIT; with sync==0, stay in IDLE.
REQ-015 PRESS_WAIT, on a sample with sync==cand: cnt++; when the incremented value equals DB_COUNT, go to HELD, rows_clean<=cand, press_pulse=1 next clk, cnt<=0.
REQ-016 PRESS_WAIT, on a sample with sync==0: go to IDLE, cnt<=0.
REQ-017 PRESS_WAIT, on a sample with sync nonzero and !=cand: cand<=sync, cnt<=1, stay in PRESS_WAIT.
REQ-018 HELD, on a sample with sync!=cand: go to REL_WAIT, cnt<=1; with sync==cand, stay in HELD.
REQ-019 REL_WAIT, on a sample with sync==cand: return to HELD, cnt<=0, no pulse (bounce absorbed).
REQ-020 REL_WAIT, on a sample with sync!=cand: cnt++; when the incremented value equals DB_COUNT, go to IDLE, rows_clean<=0, cand<=0, release_pulse=1 next clk.
REQ-021 A different key pressed during REL_WAIT SHALL count as a mismatch; it is accepted as a new press only via IDLE after the release completes.
REQ-022 All outputs SHALL be registered; no combinational path from rows_raw to any output.
REQ-023 Press latency from a stable rows_raw edge, with sample_en tied high, SHALL be SYNC_STAGES + DB_COUNT + 1 clks to press_pulse; release latency SHALL be the same.
REQ-024 rows_clean SHALL change only in the same cycle press_pulse or release_pulse is asserted.
REQ-025 press_pulse and release_pulse SHALL never be high in the same cycle.

Reset
REQ-026 When reset_n is low: sync flops=0, state=IDLE, cand=0, cnt=0, rows_clean=0, key_down=0, press_pulse=0, release_pulse=0, asynchronously.
REQ-027 Reset asserted mid-debounce SHALL discard all progress; after deassertion, a held key SHALL be re-qualified from IDLE with full latency.

Structure
REQ-028 The shared package keypad_pkg SHALL hold NUM_ROWS=4 and the state enum kbd_db_state_t {IDLE, PRESS_WAIT, HELD, REL_WAIT}.
REQ-029 The synchronizer chain SHALL be a sub-module named sync_chain (params WIDTH, STAGES), reset by reset_n.
REQ-030 The implementation SHALL fit in 120-400 lines including sync_chain.

Verification (DB_COUNT=4, SYNC_STAGES=2, sample_en=1 unless stated)
REQ-031 Clean press: rows_raw 0000->0100 held -> press_pulse high at clk 7, rows_clean=0100, key_down=1.
REQ-032 Bounce on press: 0100 for 2 clks, 0000 for 1 clk, then 0100 held -> FSM returns to IDLE, then press_pulse 7 clks after the final rise; exactly one press_pulse.
REQ-033 Bounce on release: key held, then 0000 for 2 clks, 0100 for 1 clk, then 0000 held -> no release_pulse until 7 clks after the final fall; rows_clean stays 0100 until then.
REQ-034 Gated sampling: sample_en high every 4th clk, clean press 0001 -> press_pulse on the clk after the 4th qualifying sample; rows_clean=0001.
REQ-035 Key change while waiting: 0010 for 3 clks, then 1000 held -> cand switches, press_pulse reports rows_clean=1000 only, never 0010.
REQ-036 Reset mid-PRESS_WAIT (cnt=3), key still held -> all outputs 0 immediately; press_pulse 7 clks after reset_n rises.
